phase_meas_scheduler: RTL and testbench
=======================================

PHASE_MEAS_SCHEDULER -- requirements
Module: phase_meas_scheduler

Interface
REQ-001 Parameter M, default 14: width of signed sample and offset inputs.
REQ-002 Parameter SETTLE, default 4: idle cycles after switching the engine input mux before the engine starts.
REQ-003 Parameter TIMEOUT, default 4096: maximum cycles the block waits for eng_done; must be at least 2.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 en  in  1  high = run measurement rounds continuously; low = stop at the next IDLE or STORE.
REQ-007 vb, vc  in  M each, signed  phase B and phase C samples.
REQ-008 off_b, off_c  in  M each, signed  zero-crossing offsets for B and C.
REQ-009 eng_vin  out  M, signed  sample routed to the shared phase engine: vb when sel=0, vc when sel=1.
REQ-010 eng_off  out  M, signed  offset routed to the engine, selected by sel in the same way.
REQ-011 eng_start  out  1  one-cycle pulse that starts an engine measurement.
REQ-012 eng_done  in  1  one-cycle engine completion strobe; eng_phase is valid in that cycle.
REQ-013 eng_phase  in  16  engine result in unsigned degrees.
REQ-014 sel  out  1  current channel: 0 = B, 1 = C.
REQ-015 phase_b, phase_c  out  16 each  last good result per channel.
REQ-016 valid_b, valid_c  out  1 each  high = the stored result came from the most recent attempt on that channel.
REQ-017 err_b, err_c  out  1 each  sticky timeout flag per channel.
REQ-018 err_clr  in  1  clears err_b and err_c.
REQ-019 rounds  out  8  count of completed B+C rounds, wraps 255 to 0.
REQ-020 busy  out  1  high in every state except IDLE.

Function
REQ-021 FSM states: IDLE, SETTLE, START, WAIT, STORE.
REQ-022 IDLE: if en=1, go to SETTLE and load the cycle counter with 0; otherwise stay in IDLE.
REQ-023 SETTLE: increment the counter each cycle; go to START when counter = SETTLE-1, so SETTLE spends exactly SETTLE cycles.
REQ-024 START: drive eng_start=1 for exactly this one cycle, clear the counter, then go to WAIT.
REQ-025 WAIT: if eng_done=1, capture eng_phase into the register of the current channel, set that channel's valid bit, then go to STORE.
REQ-026 WAIT: if eng_done=0 and counter = TIMEOUT-1, set that channel's err bit, clear its valid bit, keep its phase register unchanged, then go to STORE.
REQ-027 WAIT: otherwise increment the counter.
REQ-028 If eng_done and timeout occur in the same cycle, eng_done wins and err is not set.
REQ-029 eng_done is ignored in every state other than WAIT.
REQ-030 STORE: toggle sel; if sel was 1 (C finished), increment rounds modulo 256.
REQ-031 STORE next state: SETTLE with counter 0 if en=1, else IDLE.
REQ-032 en going low in SETTLE, START or WAIT does not abort the measurement in progress; it completes and the FSM stops at STORE.
REQ-033 eng_vin and eng_off are combinational from sel and the current inputs; sel changes only in STORE.
REQ-034 err_clr has priority over a simultaneous timeout set: err bits read 0 after that cycle.
REQ-035 The counter is at least ceil(log2(max(SETTLE, TIMEOUT))) bits wide and never wraps inside a state.
REQ-036 Latency from entering SETTLE to eng_start is SETTLE cycles; eng_start is asserted one cycle before WAIT.

Reset
REQ-037 On rst, the FSM goes to IDLE and sel, counter, phase_b, phase_c, valid_b, valid_c, err_b, err_c, rounds, eng_start and busy go to 0.
REQ-038 Reset asserted mid-WAIT discards the pending measurement; a later eng_done before the next START has no effect.

Verification
REQ-039 en=1, engine returns done with eng_phase=120 after 50 cycles on B and 240 on C -> phase_b=120, phase_c=240, valid_b=valid_c=1, rounds=1, eng_start high 4 cycles after each channel switch.
REQ-040 TIMEOUT=16, no eng_done on C -> err_c=1 after 16 WAIT cycles, valid_c=0, phase_c keeps its prior value, FSM proceeds to B.
REQ-041 eng_done in the same cycle as timeout -> result captured, err clear.
REQ-042 en dropped during WAIT -> measurement completes, STORE, then IDLE with busy=0; sel has toggled.
REQ-043 rst pulsed mid-WAIT, then a stray eng_done -> all outputs 0, no capture, FSM stays in IDLE while en=0.
REQ-044 256 rounds -> rounds wraps to 0; err_clr asserted together with a timeout -> err reads 0.

Source files
------------

// File: rtl/phase_meas_scheduler.sv
// Phase measurement scheduler: time-shares one phase engine between the
// B and C channels, with a settle delay after each mux switch, a bounded
// wait for the engine result, per-channel result/valid/error registers
// and a completed-round counter.
module phase_meas_scheduler #(
  parameter int M       = 14,
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic signed [M-1:0] vb,
  input  logic signed [M-1:0] vc,
  input  logic signed [M-1:0] off_b,
  input  logic signed [M-1:0] off_c,
  output logic signed [M-1:0] eng_vin,
  output logic signed [M-1:0] eng_off,
  output logic                eng_start,
  input  logic                eng_done,
  input  logic [15:0]         eng_phase,
  output logic                sel,
  output logic [15:0]         phase_b,
  output logic [15:0]         phase_c,
  output logic                valid_b,
  output logic                valid_c,
  output logic                err_b,
  output logic                err_c,
  input  logic                err_clr,
  output logic [7:0]          rounds,
  output logic                busy
);

  // One counter serves both the settle delay and the engine timeout, so it
  // is sized for the larger of the two terminal counts.
  localparam int MAXC = (SETTLE > TIMEOUT) ? SETTLE : TIMEOUT;
  localparam int CW   = (MAXC < 2) ? 1 : $clog2(MAXC);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_START,
    ST_WAIT,
    ST_STORE
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          cap;      // engine result accepted this cycle
  logic          tmo;      // engine timed out this cycle

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state, counter and capture/timeout decisions.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    cap        = 1'b0;
    tmo        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (en) begin
          state_next = ST_SETTLE;
          cnt_next   = '0;
        end
      end
      ST_SETTLE: begin
        if (cnt == CW'(SETTLE - 1)) begin
          state_next = ST_START;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      ST_START: begin
        cnt_next   = '0;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        // A done strobe on the final wait cycle still counts as success.
        if (eng_done) begin
          cap        = 1'b1;
          state_next = ST_STORE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          tmo        = 1'b1;
          state_next = ST_STORE;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      ST_STORE: begin
        if (en) begin
          state_next = ST_SETTLE;
          cnt_next   = '0;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Per-channel result registers, sticky errors, channel select and rounds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel     <= 1'b0;
      phase_b <= '0;
      phase_c <= '0;
      valid_b <= 1'b0;
      valid_c <= 1'b0;
      err_b   <= 1'b0;
      err_c   <= 1'b0;
      rounds  <= '0;
    end else begin
      if (cap) begin
        if (sel) begin
          phase_c <= eng_phase;
          valid_c <= 1'b1;
        end else begin
          phase_b <= eng_phase;
          valid_b <= 1'b1;
        end
      end
      if (tmo) begin
        if (sel) begin
          err_c   <= 1'b1;
          valid_c <= 1'b0;
        end else begin
          err_b   <= 1'b1;
          valid_b <= 1'b0;
        end
      end
      // Clearing wins over a timeout landing in the same cycle.
      if (err_clr) begin
        err_b <= 1'b0;
        err_c <= 1'b0;
      end
      if (state == ST_STORE) begin
        sel <= ~sel;
        if (sel) begin
          rounds <= rounds + 8'd1;
        end
      end
    end
  end

  // Engine input mux and status outputs decoded from the current state.
  always_comb begin
    eng_vin   = sel ? vc    : vb;
    eng_off   = sel ? off_c : off_b;
    eng_start = (state == ST_START);
    busy      = (state != ST_IDLE);
  end

endmodule

// File: tb/tb_phase_meas_scheduler.sv
// Directed bench for phase_meas_scheduler with SETTLE=4, TIMEOUT=16.
// A short timeout keeps the wrap test fast, so the nominal engine latency
// used here is 10 cycles rather than 50.
module tb_phase_meas_scheduler;

  localparam int M_P       = 14;
  localparam int SETTLE_P  = 4;
  localparam int TIMEOUT_P = 16;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  en;
  logic signed [M_P-1:0] vb, vc, off_b, off_c;
  logic signed [M_P-1:0] eng_vin, eng_off;
  logic                  eng_start;
  logic                  eng_done;
  logic [15:0]           eng_phase;
  logic                  sel;
  logic [15:0]           phase_b, phase_c;
  logic                  valid_b, valid_c, err_b, err_c;
  logic                  err_clr;
  logic [7:0]            rounds;
  logic                  busy;

  int vectors    = 0;
  int miscompares = 0;

  phase_meas_scheduler #(.M(M_P), .SETTLE(SETTLE_P), .TIMEOUT(TIMEOUT_P)) dut (
    .clk(clk), .rst(rst), .en(en),
    .vb(vb), .vc(vc), .off_b(off_b), .off_c(off_c),
    .eng_vin(eng_vin), .eng_off(eng_off), .eng_start(eng_start),
    .eng_done(eng_done), .eng_phase(eng_phase), .sel(sel),
    .phase_b(phase_b), .phase_c(phase_c), .valid_b(valid_b), .valid_c(valid_c),
    .err_b(err_b), .err_c(err_c), .err_clr(err_clr), .rounds(rounds), .busy(busy)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one channel measurement, entered in the first SETTLE cycle and left in STORE.
  // d: WAIT cycle (1-based) in which eng_done pulses; give=0 lets the wait time out.
  task automatic meas(input int d, input logic [15:0] ph, input bit give,
                      input bit drop, input bit clr, input string nm);
    int n;
    n = 0;
    while (eng_start !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    vectors++;
    if (n != SETTLE_P) begin
      miscompares++;
      $display("FAIL %s start_latency got=%0d exp=%0d", nm, n, SETTLE_P);
    end
    for (int k = 1; k <= TIMEOUT_P; k++) begin
      tick();
      if (drop && k == 1) en = 1'b0;
      if (give && k == d) begin
        eng_phase = ph;
        eng_done  = 1'b1;
        tick();
        eng_done  = 1'b0;
        break;
      end
    end
    if (!give) begin
      if (clr) err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
    end
    $display("meas %s sel=%0d phase_b=%0d phase_c=%0d vb=%0d vc=%0d err_b=%0d err_c=%0d rounds=%0d",
             nm, sel, phase_b, phase_c, valid_b, valid_c, err_b, err_c, rounds);
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b0; eng_done = 1'b0; eng_phase = 16'd0; err_clr = 1'b0;
    vb = 14'sd100; vc = -14'sd200; off_b = 14'sd7; off_c = -14'sd9;
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({sel, phase_b, phase_c, valid_b, valid_c, err_b, err_c, rounds, eng_start, busy} !== '0) begin
      miscompares++;
      $display("FAIL reset_state got sel=%0d pb=%0d pc=%0d vb=%0d vc=%0d eb=%0d ec=%0d r=%0d st=%0d busy=%0d exp all 0",
               sel, phase_b, phase_c, valid_b, valid_c, err_b, err_c, rounds, eng_start, busy);
    end
    tick();
    rst = 1'b0;
    tick();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_hold busy got=%0d exp=0", busy);
    end
    $display("test_reset done");
  endtask

  task automatic test_normal_round();
    en = 1'b1;
    tick();
    vectors++;
    if (eng_vin !== 14'sd100 || eng_off !== 14'sd7) begin
      miscompares++;
      $display("FAIL mux_b got vin=%0d off=%0d exp vin=100 off=7", eng_vin, eng_off);
    end
    meas(10, 16'd120, 1'b1, 1'b0, 1'b0, "B1");
    vectors++;
    if (phase_b !== 16'd120 || valid_b !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL capture_b got phase=%0d valid=%0d busy=%0d exp 120 1 1", phase_b, valid_b, busy);
    end
    tick();
    vectors++;
    if (sel !== 1'b1 || eng_vin !== -14'sd200 || eng_off !== -14'sd9) begin
      miscompares++;
      $display("FAIL mux_c got sel=%0d vin=%0d off=%0d exp 1 -200 -9", sel, eng_vin, eng_off);
    end
    meas(10, 16'd240, 1'b1, 1'b0, 1'b0, "C1");
    vectors++;
    if (phase_c !== 16'd240 || valid_c !== 1'b1 || rounds !== 8'd0) begin
      miscompares++;
      $display("FAIL capture_c got phase=%0d valid=%0d rounds=%0d exp 240 1 0", phase_c, valid_c, rounds);
    end
    tick();
    vectors++;
    if (rounds !== 8'd1 || sel !== 1'b0) begin
      miscompares++;
      $display("FAIL round1 got rounds=%0d sel=%0d exp 1 0", rounds, sel);
    end
  endtask

  task automatic test_timeout();
    meas(5, 16'd300, 1'b1, 1'b0, 1'b0, "B2");
    tick();
    meas(0, 16'd0, 1'b0, 1'b0, 1'b0, "C2_timeout");
    vectors++;
    if (err_c !== 1'b1 || valid_c !== 1'b0 || phase_c !== 16'd240 || err_b !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_c got err_c=%0d valid_c=%0d phase_c=%0d err_b=%0d exp 1 0 240 0",
               err_c, valid_c, phase_c, err_b);
    end
    tick();
    vectors++;
    if (sel !== 1'b0 || rounds !== 8'd2 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL after_timeout got sel=%0d rounds=%0d busy=%0d exp 0 2 1", sel, rounds, busy);
    end
  endtask

  task automatic test_done_at_timeout();
    meas(TIMEOUT_P, 16'd77, 1'b1, 1'b0, 1'b0, "B3_edge");
    vectors++;
    if (phase_b !== 16'd77 || valid_b !== 1'b1 || err_b !== 1'b0) begin
      miscompares++;
      $display("FAIL done_vs_timeout_b got phase=%0d valid=%0d err=%0d exp 77 1 0", phase_b, valid_b, err_b);
    end
    tick();
    meas(TIMEOUT_P, 16'd88, 1'b1, 1'b0, 1'b0, "C3_edge");
    vectors++;
    if (phase_c !== 16'd88 || valid_c !== 1'b1 || err_c !== 1'b1) begin
      miscompares++;
      $display("FAIL done_vs_timeout_c got phase=%0d valid=%0d err=%0d exp 88 1 1(sticky)", phase_c, valid_c, err_c);
    end
    tick();
  endtask

  task automatic test_en_drop();
    meas(8, 16'd500, 1'b1, 1'b1, 1'b0, "B4_drop");
    vectors++;
    if (phase_b !== 16'd500 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL en_drop_complete got phase_b=%0d busy=%0d exp 500 1", phase_b, busy);
    end
    tick();
    vectors++;
    if (busy !== 1'b0 || sel !== 1'b1) begin
      miscompares++;
      $display("FAIL en_drop_idle got busy=%0d sel=%0d exp 0 1", busy, sel);
    end
    tick(); tick(); tick();
    vectors++;
    if (busy !== 1'b0 || eng_start !== 1'b0 || rounds !== 8'd3) begin
      miscompares++;
      $display("FAIL en_drop_stay got busy=%0d start=%0d rounds=%0d exp 0 0 3", busy, eng_start, rounds);
    end
  endtask

  task automatic test_rst_mid_wait();
    int n;
    en = 1'b1;
    tick();
    n = 0;
    while (eng_start !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    tick(); tick();
    en = 1'b0;
    #2 rst = 1'b1;
    tick();
    rst = 1'b0;
    eng_phase = 16'd999;
    eng_done  = 1'b1;
    tick();
    eng_done  = 1'b0;
    tick(); tick();
    vectors++;
    if ({sel, phase_b, phase_c, valid_b, valid_c, err_b, err_c, rounds, eng_start, busy} !== '0) begin
      miscompares++;
      $display("FAIL rst_mid_wait got sel=%0d pb=%0d pc=%0d vb=%0d vc=%0d eb=%0d ec=%0d r=%0d st=%0d busy=%0d exp all 0",
               sel, phase_b, phase_c, valid_b, valid_c, err_b, err_c, rounds, eng_start, busy);
    end
  endtask

  task automatic test_wrap_and_clr();
    en = 1'b1;
    tick();
    for (int r = 0; r < 255; r++) begin
      meas(1, 16'(r), 1'b1, 1'b0, 1'b0, "wrapB");
      tick();
      meas(1, 16'(r + 1000), 1'b1, 1'b0, 1'b0, "wrapC");
      tick();
    end
    vectors++;
    if (rounds !== 8'd255 || phase_c !== 16'd1254) begin
      miscompares++;
      $display("FAIL rounds_255 got rounds=%0d phase_c=%0d exp 255 1254", rounds, phase_c);
    end
    meas(2, 16'd11, 1'b1, 1'b0, 1'b0, "lastB");
    tick();
    meas(0, 16'd0, 1'b0, 1'b1, 1'b1, "lastC_clr");
    vectors++;
    if (err_c !== 1'b0 || valid_c !== 1'b0 || phase_c !== 16'd1254) begin
      miscompares++;
      $display("FAIL clr_vs_timeout got err_c=%0d valid_c=%0d phase_c=%0d exp 0 0 1254", err_c, valid_c, phase_c);
    end
    tick();
    vectors++;
    if (rounds !== 8'd0 || busy !== 1'b0 || sel !== 1'b0) begin
      miscompares++;
      $display("FAIL rounds_wrap got rounds=%0d busy=%0d sel=%0d exp 0 0 0", rounds, busy, sel);
    end
  endtask

  initial begin
    test_reset();
    test_normal_round();
    test_timeout();
    test_done_at_timeout();
    test_en_drop();
    test_rst_mid_wait();
    test_wrap_and_clr();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
